// File: rtl/mem_bus_pkg.sv
// Shared constants for the main-memory bus responder.
// State codes, default widths and the read-latency range check.
package mem_bus_pkg;

    localparam int ADDR_W_DEF   = 32;
    localparam int DATA_W_DEF   = 32;
    localparam int WORDS_L2_DEF = 10;
    localparam int RD_LAT_DEF   = 4;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 15;
    localparam int CNT_W      = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_WAIT  = 3'd1;
    localparam state_t ST_REQ   = 3'd2;
    localparam state_t ST_DRIVE = 3'd3;
    localparam state_t ST_WACK  = 3'd4;

    function automatic bit lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// Common-bus signal bundle between cache side and memory agent.
// master: bus/arbiter side; slave: memory responder.
interface mem_bus_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] Address_Com;
    logic                  BusRd;
    logic                  BusRdX;
    logic                  Mem_wr;
    logic                  Mem_oprn_abort;
    logic [DATA_WIDTH-1:0] Data_Bus_Com_in;
    logic [DATA_WIDTH-1:0] Data_Bus_Com_out;
    logic                  Data_Bus_Com_oe;
    logic                  Data_in_Bus;
    logic                  Mem_write_done;
    logic                  Mem_snoop_req;
    logic                  Mem_snoop_gnt;

    modport master (
        output Address_Com, BusRd, BusRdX, Mem_wr,
        output Mem_oprn_abort, Data_Bus_Com_in,
        output Mem_snoop_gnt,
        input  Data_Bus_Com_out, Data_Bus_Com_oe,
        input  Data_in_Bus, Mem_write_done,
        input  Mem_snoop_req
    );

    modport slave (
        input  Address_Com, BusRd, BusRdX, Mem_wr,
        input  Mem_oprn_abort, Data_Bus_Com_in,
        input  Mem_snoop_gnt,
        output Data_Bus_Com_out, Data_Bus_Com_oe,
        output Data_in_Bus, Mem_write_done,
        output Mem_snoop_req
    );
endinterface

// File: rtl/mem_word_store.sv
// Backing word array: synchronous write, combinational read.
// Ports: waddr_i/wdata_i/we_i write, raddr_i -> rdata_o read.
module mem_word_store #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          we_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_bus_responder.sv
// Main-memory agent: serves BusRd/BusRdX after a fixed latency
// via arbiter req/gnt, absorbs write-backs, honours read abort.
// Ports: clk, rst_n (async low), bus (slave modport of the
// common-bus interface).
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_W_DEF,
    parameter int DATA_WIDTH     = DATA_W_DEF,
    parameter int MEM_WORDS_LOG2 = WORDS_L2_DEF,
    parameter int RD_LATENCY     = RD_LAT_DEF
) (
    input logic clk,
    input logic rst_n,
    mem_bus_responder_if.slave bus
);
    localparam int IW = MEM_WORDS_LOG2;

    if (!lat_legal(RD_LATENCY)) begin : g_bad_lat
        $error("RD_LATENCY out of range 1..15");
    end

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]         raddr_q, raddr_d;
    logic                  req_q, req_d;
    logic                  drv_q, drv_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  done_q, done_d;
    logic                  armed_q, armed_d;

    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] rd_fwd;
    logic                  rd_cmd;
    logic                  wr_slot;
    logic                  wr_fire;
    logic                  we;
    logic                  unused_addr;

    assign idx    = bus.Address_Com[IW+1:2];
    assign rd_cmd = bus.BusRd | bus.BusRdX;

    assign unused_addr = ^{bus.Address_Com[ADDR_WIDTH-1:IW+2],
                           bus.Address_Com[1:0]};

    // Writes are taken in IDLE and while a read is pending;
    // in RD_DRIVE/WR_ACK a fresh request waits (Mem_wr is held).
    assign wr_slot = (state_q == ST_IDLE) ||
                     (state_q == ST_WAIT) ||
                     (state_q == ST_REQ);
    // armed_q needs Mem_wr seen low since the last accepted
    // write, so one held request yields one write.
    assign wr_fire = bus.Mem_wr & armed_q & wr_slot;
    assign we      = wr_fire & rst_n;

    // Same-edge write to the latched word beats stale data.
    assign rd_fwd = (wr_fire && idx == raddr_q)
                  ? bus.Data_Bus_Com_in : rdata;

    mem_word_store #(
        .AW (IW),
        .DW (DATA_WIDTH)
    ) u_store (
        .clk     (clk),
        .waddr_i (idx),
        .wdata_i (bus.Data_Bus_Com_in),
        .we_i    (we),
        .raddr_i (raddr_q),
        .rdata_o (rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        raddr_d = raddr_q;
        req_d   = req_q;
        drv_d   = drv_q;
        dout_d  = dout_q;
        done_d  = wr_fire;
        armed_d = armed_q;

        if (wr_fire) begin
            armed_d = 1'b0;
        end else if (!bus.Mem_wr) begin
            armed_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_fire) begin
                    state_d = ST_WACK;
                end else if (rd_cmd) begin
                    raddr_d = idx;
                    cnt_d   = CNT_W'(RD_LATENCY - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.Mem_oprn_abort) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_REQ: begin
                if (bus.Mem_oprn_abort) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (bus.Mem_snoop_gnt) begin
                    dout_d  = rd_fwd;
                    drv_d   = 1'b1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                req_d   = 1'b0;
                drv_d   = 1'b0;
                dout_d  = '0;
                state_d = ST_IDLE;
            end
            ST_WACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                drv_d   = 1'b0;
                dout_d  = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            raddr_q <= '0;
            req_q   <= 1'b0;
            drv_q   <= 1'b0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            raddr_q <= raddr_d;
            req_q   <= req_d;
            drv_q   <= drv_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            armed_q <= armed_d;
        end
    end

    assign bus.Mem_snoop_req    = req_q;
    assign bus.Data_in_Bus      = drv_q;
    assign bus.Data_Bus_Com_oe  = drv_q;
    assign bus.Data_Bus_Com_out = dout_q;
    assign bus.Mem_write_done   = done_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder.
// Hand-computed vectors; one check task counts every compare.
module tb_mem_bus_responder;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    mem_bus_responder_if #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) bus ();

    mem_bus_responder #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .MEM_WORDS_LOG2 (10),
        .RD_LATENCY     (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.Address_Com     = '0;
        bus.BusRd           = 1'b0;
        bus.BusRdX          = 1'b0;
        bus.Mem_wr          = 1'b0;
        bus.Mem_oprn_abort  = 1'b0;
        bus.Data_Bus_Com_in = '0;
        bus.Mem_snoop_gnt   = 1'b0;
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_req"}, 32'(bus.Mem_snoop_req), 0);
        chk({tag, "_oe"}, 32'(bus.Data_Bus_Com_oe), 0);
        chk({tag, "_dib"}, 32'(bus.Data_in_Bus), 0);
        chk({tag, "_done"}, 32'(bus.Mem_write_done), 0);
        chk({tag, "_dout"}, bus.Data_Bus_Com_out, 0);
    endtask

    task automatic do_write(input logic [31:0] a,
                            input logic [31:0] d);
        bus.Address_Com     = a;
        bus.Data_Bus_Com_in = d;
        bus.Mem_wr          = 1'b1;
        tick();
        chk("wr_done_hi", 32'(bus.Mem_write_done), 1);
        bus.Mem_wr = 1'b0;
        tick();
        chk("wr_done_lo", 32'(bus.Mem_write_done), 0);
    endtask

    task automatic issue_read(input logic [31:0] a,
                              input bit rdx);
        bus.Address_Com = a;
        bus.BusRd       = ~rdx;
        bus.BusRdX      = rdx;
        tick();
        bus.BusRd  = 1'b0;
        bus.BusRdX = 1'b0;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (bus.Mem_snoop_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic finish_read(input int dly,
                               input logic [31:0] exp);
        int n;
        bit ok;
        wait_req(n);
        chk("req_seen", 32'(n < 20), 1);
        ok = 1'b1;
        for (int i = 0; i < dly; i++) begin
            tick();
            if (bus.Mem_snoop_req !== 1'b1) ok = 1'b0;
            if (bus.Data_in_Bus !== 1'b0) ok = 1'b0;
        end
        chk("req_hold", 32'(ok), 1);
        bus.Mem_snoop_gnt = 1'b1;
        tick();
        bus.Mem_snoop_gnt = 1'b0;
        chk("drv_dib", 32'(bus.Data_in_Bus), 1);
        chk("drv_oe", 32'(bus.Data_Bus_Com_oe), 1);
        chk("drv_req", 32'(bus.Mem_snoop_req), 1);
        chk("drv_data", bus.Data_Bus_Com_out, exp);
        tick();
        outs_zero("post_drv");
    endtask

    task automatic do_read(input logic [31:0] a,
                           input bit rdx,
                           input int dly,
                           input logic [31:0] exp);
        int n;
        issue_read(a, rdx);
        chk("cap_req", 32'(bus.Mem_snoop_req), 0);
        wait_req(n);
        chk("rd_latency", 32'(n), 4);
        finish_read(dly, exp);
    endtask

    initial begin
        int n;
        int pulses;
        bit ok;
        n_chk  = 0;
        n_pass = 0;
        idle_in();
        rst_n = 1'b0;
        repeat (3) tick();
        outs_zero("rst");
        rst_n = 1'b1;
        repeat (2) tick();
        outs_zero("idle");

        do_write(32'h0000_0010, 32'hDEAD_BEEF);
        do_read(32'h0000_0010, 1'b0, 0, 32'hDEAD_BEEF);

        do_read(32'h0000_0010, 1'b1, 7, 32'hDEAD_BEEF);

        // Aliased address: same index, other bits differ.
        do_read(32'h0000_1013, 1'b0, 1, 32'hDEAD_BEEF);

        // Abort coincident with grant.
        issue_read(32'h0000_0010, 1'b0);
        wait_req(n);
        chk("ab_req_seen", 32'(n), 4);
        bus.Mem_snoop_gnt  = 1'b1;
        bus.Mem_oprn_abort = 1'b1;
        tick();
        bus.Mem_snoop_gnt  = 1'b0;
        bus.Mem_oprn_abort = 1'b0;
        outs_zero("ab_gnt");
        tick();
        do_read(32'h0000_0010, 1'b0, 0, 32'hDEAD_BEEF);

        // Abort during the latency wait.
        issue_read(32'h0000_0010, 1'b0);
        bus.Mem_oprn_abort = 1'b1;
        tick();
        bus.Mem_oprn_abort = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.Mem_snoop_req !== 1'b0) ok = 1'b0;
        end
        chk("ab_wait_noreq", 32'(ok), 1);

        // Write to the latched word while the read waits.
        do_write(32'h0000_0020, 32'h1111_1111);
        issue_read(32'h0000_0020, 1'b0);
        bus.Mem_wr          = 1'b1;
        bus.Data_Bus_Com_in = 32'h2222_2222;
        tick();
        bus.Mem_wr = 1'b0;
        chk("wdr_done_hi", 32'(bus.Mem_write_done), 1);
        chk("wdr_no_req", 32'(bus.Mem_snoop_req), 0);
        tick();
        chk("wdr_done_lo", 32'(bus.Mem_write_done), 0);
        finish_read(0, 32'h2222_2222);

        // Write + read together, write held three cycles.
        bus.Address_Com     = 32'h0000_0030;
        bus.Data_Bus_Com_in = 32'h3333_3333;
        bus.Mem_wr          = 1'b1;
        bus.BusRd           = 1'b1;
        pulses = 0;
        ok     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.BusRd = 1'b0;
            if (bus.Mem_write_done === 1'b1) pulses++;
        end
        bus.Mem_wr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.Mem_write_done === 1'b1) pulses++;
            if (bus.Mem_snoop_req !== 1'b0) ok = 1'b0;
        end
        chk("held_wr_pulses", 32'(pulses), 1);
        chk("prio_no_read", 32'(ok), 1);
        do_read(32'h0000_0030, 1'b0, 0, 32'h3333_3333);

        // Async reset in RD_REQ; write attempt under reset.
        issue_read(32'h0000_0010, 1'b0);
        wait_req(n);
        chk("rst_req_seen", 32'(bus.Mem_snoop_req), 1);
        #2;
        rst_n = 1'b0;
        #1;
        outs_zero("rst_async");
        bus.Address_Com     = 32'h0000_0010;
        bus.Data_Bus_Com_in = 32'h0BAD_0BAD;
        bus.Mem_wr          = 1'b1;
        tick();
        bus.Mem_wr = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        outs_zero("rst_rel");
        do_read(32'h0000_0010, 1'b0, 0, 32'hDEAD_BEEF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Main-memory agent on the shared common bus, downstream of the per-core cache wrappers and peer to the bus arbiter.
- Services BusRd/BusRdX misses: after a fixed access latency it requests the bus through Mem_snoop_req/Mem_snoop_gnt and returns the word with Data_in_Bus.
- Absorbs dirty write-backs (Mem_wr) and acknowledges each with Mem_write_done.
- Cancels a pending read when Mem_oprn_abort signals that a snooping cache supplies the line.

Parameters:
- ADDR_WIDTH, 32, width of Address_Com.
- DATA_WIDTH, 32, width of the common data bus.
- MEM_WORDS_LOG2, 10, backing store holds 2**MEM_WORDS_LOG2 words, indexed by Address_Com[MEM_WORDS_LOG2+1:2].
- RD_LATENCY, 4, cycles from read capture to Mem_snoop_req assertion; legal range 1..15.

Ports:
- clk  in  1  bus clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Address_Com  in  ADDR_WIDTH  common-bus address.
- BusRd  in  1  read-miss request.
- BusRdX  in  1  read-for-ownership request, handled identically to BusRd.
- Mem_wr  in  1  write-back request (level); held by the requester until Mem_write_done.
- Mem_oprn_abort  in  1  a cache is supplying data; cancel the pending read.
- Data_Bus_Com_in  in  DATA_WIDTH  write-back data.
- Data_Bus_Com_out  out  DATA_WIDTH  read data.
- Data_Bus_Com_oe  out  1  drive enable for Data_Bus_Com_out.
- Data_in_Bus  out  1  read data is valid on the bus this cycle.
- Mem_write_done  out  1  one-cycle write acknowledge.
- Mem_snoop_req  out  1  bus request to the arbiter.
- Mem_snoop_gnt  in  1  bus grant from the arbiter.

Behaviour:
- Reset (async, rst_n low): all outputs 0, Data_Bus_Com_out 0, state IDLE, counter 0. Store contents are not reset.
- Reset mid-operation: drops req, oe and Data_in_Bus immediately; nothing is written.
- States: IDLE, RD_WAIT, RD_REQ, RD_DRIVE, WR_ACK.
- IDLE:
  - If Mem_wr: write Data_Bus_Com_in to word[Address_Com] on this edge; go to WR_ACK.
  - Else if BusRd|BusRdX: latch address; counter <= RD_LATENCY-1; go to RD_WAIT.
  - Mem_wr has priority over a simultaneous read.
- RD_WAIT:
  - Counter decrements each cycle. At 0, go to RD_REQ with Mem_snoop_req=1 registered.
  - Net effect: req is first high RD_LATENCY cycles after the capture edge.
- RD_REQ:
  - Hold Mem_snoop_req until Mem_snoop_gnt is sampled high.
  - On grant: register word[latched addr] into Data_Bus_Com_out; go to RD_DRIVE.
- RD_DRIVE:
  - Exactly one cycle with Data_in_Bus=1, Data_Bus_Com_oe=1 and Mem_snoop_req=1.
  - Next edge: all three go to 0; return to IDLE.
- WR_ACK:
  - Mem_write_done=1 for exactly one cycle; return to IDLE.
  - Mem_wr still high in that IDLE cycle is not re-accepted. A new write requires Mem_wr to have been low for at least one cycle (rising-edge qualified).
- Abort: Mem_oprn_abort in RD_WAIT or RD_REQ returns to IDLE next edge with req=0 and no data driven. Abort coincident with grant: abort wins. Abort in IDLE, RD_DRIVE or WR_ACK is ignored.
- Write during a read: Mem_wr in RD_WAIT/RD_REQ performs the write immediately (same edge), keeps the read state, and pulses Mem_write_done one cycle later. A write to the latched address makes the pending read return the new data.
- Busy: BusRd/BusRdX arriving in any non-IDLE state is ignored; the arbiter serialises requests.
- Addresses are word-aligned; Address_Com[1:0] and bits above the index are ignored (aliasing permitted).

Decomposition:
- Package mem_bus_pkg: state enum (IDLE, RD_WAIT, RD_REQ, RD_DRIVE, WR_ACK), default widths, and a latency-range check constant.
- Sub-module mem_word_store: synchronous-write, combinational-read array (waddr, wdata, we, raddr, rdata). Instantiated once; the FSM stays in the top.

Test Plan:
- Reset: rst_n low mid-RD_REQ -> req, oe, Data_in_Bus and Mem_write_done all 0 asynchronously; state IDLE after release.
- Write then read:
  - Mem_wr, addr 0x0000_0010, data 0xDEAD_BEEF -> Mem_write_done high exactly one cycle, next cycle.
  - BusRd addr 0x10 -> req high 4 cycles after capture.
  - Grant held -> Data_in_Bus one cycle with Data_Bus_Com_out 0xDEAD_BEEF.
- Grant delay: BusRdX, gnt withheld 7 cycles -> req stays high throughout, data is driven the cycle after gnt, then all outputs return to 0.
- Abort: BusRd, Mem_oprn_abort in the same cycle as gnt -> no Data_in_Bus; req low next cycle; a following BusRd is accepted normally.
- Write during read:
  - BusRd addr 0x20 (old 0x1111_1111); Mem_wr to 0x20 with 0x2222_2222 in RD_WAIT -> Mem_write_done pulses; read returns 0x2222_2222.
- Priority and held Mem_wr: Mem_wr and BusRd in the same cycle -> write only, read ignored. Mem_wr held for 3 cycles -> exactly one Mem_write_done.
